restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//  Iterative radix-2 restoring unsigned divider. It is the inverse companion to the 4x4 Wallace-tree multiplier.
//  It divides a 2N-bit dividend (product width) by an N-bit divisor and returns a 2N-bit quotient and an N-bit remainder.
//  It produces one quotient bit per clock and uses a start/busy/done handshake.
//  It sits beside the multiplier in the arithmetic test datapath.
// PARAMETERS
//  N   4   divisor/remainder width; dividend and quotient are 2N bits wide
// PORTS
//  clk         in   1    clock; all state updates on rising edge
//  reset       in   1    synchronous, active-high reset
//  start       in   1    request; sampled only in IDLE or DONE
//  dividend    in   2N   numerator, captured on the accepting edge
//  divisor     in   N    denominator, captured on the accepting edge
//  busy        out  1    high while in RUN
//  done        out  1    one-cycle pulse: quotient/remainder valid
//  quotient    out  2N   result; held until the next accepted start
//  remainder   out  N    result; held until the next accepted start
//  div_by_zero out  1    set with done when divisor==0; held like the results
// BEHAVIOUR
//  Reset (sync, active-high):
//   - state=IDLE.
//   - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
//   - Counter and working registers are cleared.
//   - Reset wins over start on the same edge.
//   - Reset mid-RUN aborts the operation; no done is produced.
//  States: IDLE, RUN, DONE.
//   - IDLE: start=1 -> RUN. Operands are latched, counter=0, partial remainder P (N+1 bits)=0.
//   - RUN: each edge does one step:
//       P' = {P[N-1:0], D[2N-1]}, D <<= 1
//       if P' >= divisor: P = P' - divisor and shift in q=1; else P = P' and shift in q=0
//     After step 2N (counter == 2N-1): -> DONE, and quotient/remainder/div_by_zero are loaded.
//   - DONE: done=1 for exactly this one cycle.
//       start=1 -> RUN (back-to-back issue allowed); else -> IDLE.
//  Latency:
//   - Start accepted at edge k. busy=1 in cycles k+1..k+2N.
//   - done=1 in cycle k+2N+1. Throughput is one division per 2N+1 cycles.
//  start while busy=1 is ignored. Operands are not re-sampled during RUN.
//  Divisor==0:
//   - Takes the same 2N-cycle latency.
//   - quotient = all ones (2^(2N)-1), remainder = dividend[N-1:0], div_by_zero=1.
//  Arithmetic:
//   - Unsigned only. Comparison/subtraction is N+1 bits wide, so no overflow is possible.
//   - Invariant when divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
//  Outputs are registered; there is no combinational path from inputs to outputs.
// TESTING (N=4)
//  - reset, then start, dividend=0x8F, divisor=0xB -> done 9 cycles after accept; q=0x0D, r=0x0, dbz=0
//  - dividend=0xC8, divisor=0xF -> q=0x0D, r=0x5; dividend=0xFF, divisor=0x1 -> q=0xFF, r=0x0
//  - dividend=0x07, divisor=0x9 -> q=0x00, r=0x7; dividend=0x50, divisor=0x0 -> q=0xFF, r=0x0, dbz=1
//  - start pulsed again during RUN with new operands -> ignored; first result unchanged; busy stays 1 for 8 cycles
//  - reset at RUN cycle 4 -> next cycle IDLE, all outputs 0, no done pulse
//    then start in DONE cycle (back-to-back) -> second done arrives exactly 9 cycles later
//  - exhaustive: all 256x15 nonzero pairs vs a reference model (a*b round-trip with the multiplier); check the invariant every done

Source files
------------

// File: rtl/restoring_divider.sv
// Iterative radix-2 restoring unsigned divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, start/busy/done handshake with registered outputs.
module restoring_divider #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int unsigned CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] d;
    logic [N-1:0]   dv;
    logic [N-1:0]   p;
    logic [N:0]     pshift;
    logic [N-1:0]   pnext;
    logic [2*N-1:0] dnext;
    logic           qbit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // P is held N bits wide: after a step it is always below the divisor, or with a
    // zero divisor its top bit is shifted out next step anyway, so the full N+1-bit
    // value only exists transiently in pshift for the compare.
    always_comb begin
        pshift = {p, d[2*N-1]};
        qbit   = (pshift >= {1'b0, dv});
        pnext  = qbit ? (pshift[N-1:0] - dv) : pshift[N-1:0];
        dnext  = {d[2*N-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            d           <= '0;
            dv          <= '0;
            p           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        d   <= dividend;
                        dv  <= divisor;
                        p   <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    d   <= dnext;
                    p   <= pnext;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient    <= dnext;
                        remainder   <= pnext;
                        div_by_zero <= (dv == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive self-checking bench for restoring_divider (N=4).
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int fails  = 0;

    restoring_divider #(.N(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Issue one division from IDLE; returns at the negedge where done is seen (or at timeout).
    task automatic issue(input logic [7:0] a, input logic [3:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; dividend = 8'h8F; divisor = 4'hB;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_over_start: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va[5] = '{8'h8F, 8'hC8, 8'hFF, 8'h07, 8'h50};
        logic [3:0] vb[5] = '{4'hB, 4'hF, 4'h1, 4'h9, 4'h0};
        logic [7:0] vq[5] = '{8'h0D, 8'h0D, 8'hFF, 8'h00, 8'hFF};
        logic [3:0] vr[5] = '{4'h0, 4'h5, 4'h0, 4'h7, 4'h0};
        logic       vz[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], lat);
            checks++;
            if (lat !== 9) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want 9", i, lat);
            end
            checks++;
            if (quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== vz[i]) begin
                fails++;
                $display("FAIL directed_result[%0d] %h/%h: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                         i, va[i], vb[i], quotient, remainder, div_by_zero, vq[i], vr[i], vz[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int busycnt = 0;
        @(negedge clk);
        start = 1'b1; dividend = 8'h8F; divisor = 4'hB;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busycnt++;
            if (i == 2) begin
                start = 1'b1; dividend = 8'h07; divisor = 4'h9;
            end
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (busycnt !== 8) begin
            fails++;
            $display("FAIL ignored_busy_cycles: got %0d, want 8", busycnt);
        end
        checks++;
        if (done !== 1'b1 || quotient !== 8'h0D || remainder !== 4'h0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL ignored_result: got done=%b q=%h r=%h dbz=%b, want done=1 q=0d r=0 dbz=0",
                     done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 8'hC8; divisor = 4'hF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            fails++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: got activity=%b after abort, want 0", saw_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'hC8, 4'hF, lat);
        checks++;
        if (lat !== 9 || quotient !== 8'h0D || remainder !== 4'h5) begin
            fails++;
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=9 q=0d r=5", lat, quotient, remainder);
        end
        start = 1'b1; dividend = 8'hFF; divisor = 4'h1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9 || quotient !== 8'hFF || remainder !== 4'h0) begin
            fails++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h, want lat=9 q=ff r=0", lat, quotient, remainder);
        end
    endtask

    task automatic test_exhaustive();
        int lat;
        int unsigned eq, er;
        for (int unsigned a = 0; a < 256; a++) begin
            for (int unsigned b = 1; b < 16; b++) begin
                issue(8'(a), 4'(b), lat);
                eq = a / b;
                er = a % b;
                checks++;
                if (lat !== 9 || quotient !== 8'(eq) || remainder !== 4'(er) || div_by_zero !== 1'b0) begin
                    fails++;
                    $display("FAIL exh_result %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=%0d r=%0d dbz=0",
                             a, b, lat, quotient, remainder, div_by_zero, eq, er);
                end
                checks++;
                if ((int'(quotient) * int'(b) + int'(remainder)) != int'(a) || int'(remainder) >= int'(b)) begin
                    fails++;
                    $display("FAIL exh_invariant %0d/%0d: got q*b+r=%0d r=%0d, want %0d and r<%0d",
                             a, b, int'(quotient) * int'(b) + int'(remainder), remainder, a, b);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
